// File: rtl/drive_sched.sv
// Motor-drive scheduler: fixed-priority ownership of the RSLK motor datapath, code-to-H-bridge
// translation, PWM gating and dead-time before any direction reversal. Optional macro: DRIVE_SCHED_RAMP_EN.
module drive_sched #(
    parameter int NREQ     = 3,
    parameter int DEAD     = 4,
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   cmd,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NREQ-1:0]     grant,
    output logic [2:0]          active,
    output logic                busy,
    output logic                en_l,
    output logic                en_r,
    output logic                dir_l,
    output logic                dir_r
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD_T} state_t;

    localparam int DW = $clog2(DEAD + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD);
    localparam logic [DW-1:0] DEAD_PRE  = DW'(DEAD - 1);

    if (DEAD < 1 || RAMP_DIV < 1) begin : g_param_check
        $error("drive_sched: DEAD and RAMP_DIV must be at least 1");
    end

    state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [PWM_BITS-1:0] cnt, eff_duty;
    logic [NREQ-1:0] win;
    logic [2:0] wcmd, tcode, active_n;
    logic t_en_l, t_dir_l, t_en_r, t_dir_r, need_dead, launch;
    logic busy_n, en_l_n, en_r_n, dir_l_n, dir_r_n;

    // {en_l, dir_l, en_r, dir_r}; dir 1 = reverse
    function automatic logic [3:0] decode(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b1010;
            3'd2:    return 4'b1011;
            3'd3:    return 4'b1110;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

`ifdef DRIVE_SCHED_RAMP_EN
    localparam int RW = (RAMP_DIV < 2) ? 1 : $clog2(RAMP_DIV);
    logic [RW-1:0]       rcnt;
    logic [PWM_BITS-1:0] ramp;

    // Held at zero outside RUN so every entry into RUN starts the ramp from 0.
    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            ramp <= '0;
            rcnt <= '0;
        end else if (ramp > duty) begin
            ramp <= duty;
            rcnt <= '0;
        end else if (ramp < duty) begin
            if (rcnt == RW'(RAMP_DIV - 1)) begin
                rcnt <= '0;
                ramp <= ramp + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    assign eff_duty = (ramp < duty) ? ramp : duty;
`else
    assign eff_duty = duty;
`endif

    // Lowest index wins, so a higher-index request can never displace the owner.
    always_comb begin
        win  = '0;
        wcmd = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win    = '0;
                win[i] = 1'b1;
                wcmd   = cmd[3*i +: 3];
            end
        end
        tcode = (wcmd > 3'd4) ? 3'd0 : wcmd;
        {t_en_l, t_dir_l, t_en_r, t_dir_r} = decode(tcode);
        need_dead = (t_en_l && (t_dir_l != dir_l)) || (t_en_r && (t_dir_r != dir_r));
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n  = state;
        dcnt_n   = dcnt;
        dir_l_n  = dir_l;
        dir_r_n  = dir_r;
        active_n = 3'd0;
        busy_n   = 1'b0;
        en_l_n   = 1'b0;
        en_r_n   = 1'b0;
        launch   = (state != DEAD_T) || (dcnt == DEAD_LAST);

        if (!launch) begin
            busy_n = 1'b1;
            dcnt_n = dcnt + 1'b1;
            // Last dead cycle: enables still low, bridge already set to the new direction.
            if (dcnt == DEAD_PRE) begin
                if (t_en_l) dir_l_n = t_dir_l;
                if (t_en_r) dir_r_n = t_dir_r;
            end
        end else if (req == '0) begin
            state_n = IDLE;
        end else if (need_dead) begin
            state_n = DEAD_T;
            dcnt_n  = '0;
            busy_n  = 1'b1;
        end else begin
            state_n  = RUN;
            active_n = tcode;
            if (t_en_l) dir_l_n = t_dir_l;
            if (t_en_r) dir_r_n = t_dir_r;
            en_l_n = t_en_l && (cnt < eff_duty);
            en_r_n = t_en_r && (cnt < eff_duty);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dcnt   <= '0;
            cnt    <= '0;
            grant  <= '0;
            active <= 3'd0;
            busy   <= 1'b0;
            en_l   <= 1'b0;
            en_r   <= 1'b0;
            dir_l  <= 1'b0;
            dir_r  <= 1'b0;
        end else begin
            state  <= state_n;
            dcnt   <= dcnt_n;
            cnt    <= cnt + 1'b1;
            grant  <= win;
            active <= active_n;
            busy   <= busy_n;
            en_l   <= en_l_n;
            en_r   <= en_r_n;
            dir_l  <= dir_l_n;
            dir_r  <= dir_r_n;
        end
    end

endmodule

// File: tb/tb_drive_sched.sv
// Directed self-checking bench for drive_sched (default parameters, ramp macro undefined).
module tb_drive_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [8:0] cmd;
    logic [7:0] duty;
    logic [2:0] grant;
    logic [2:0] active;
    logic       busy, en_l, en_r, dir_l, dir_r;

    int n_checks = 0;
    int n_pass   = 0;
    int cl, cr;

    drive_sched dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .duty(duty),
        .grant(grant), .active(active), .busy(busy),
        .en_l(en_l), .en_r(en_r), .dir_l(dir_l), .dir_r(dir_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Samples n consecutive cycles starting with the current one.
    task automatic count_en(input int n, output int nl, output int nr);
        nl = 0;
        nr = 0;
        for (int i = 0; i < n; i++) begin
            nl += int'(en_l);
            nr += int'(en_r);
            tick();
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_en"}, {en_l, en_r}, 2'b00);
    endtask

    initial begin
        rst = 1'b1; req = '0; cmd = '0; duty = '0;
        ticks(2);
        check("rst_grant", grant, 3'b000);
        check("rst_active", active, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_dir", {dir_l, dir_r}, 2'b00);
        check_off("rst");

        // Single requester, forward at half duty.
        rst = 1'b0; req = 3'b010; cmd[5:3] = 3'd1; duty = 8'd128;
        tick();
        check("fwd_grant", grant, 3'b010);
        check("fwd_active", active, 3'd1);
        check("fwd_dir", {dir_l, dir_r}, 2'b00);
        count_en(256, cl, cr);
        check("fwd_pwm_l", cl, 128);
        check("fwd_pwm_r", cr, 128);

        // Higher-priority reverse preempts and forces dead-time.
        req = 3'b011; cmd[2:0] = 3'd4;
        tick();
        check("pre_grant", grant, 3'b001);
        check("pre_busy", busy, 1'b1);
        check("pre_active", active, 3'd0);
        for (int i = 0; i < 4; i++) begin
            check("dead_old_dir", {dir_l, dir_r}, 2'b00);
            check_off("dead_old");
            check("dead_busy", busy, 1'b1);
            tick();
        end
        check("dead_new_dir", {dir_l, dir_r}, 2'b11);
        check_off("dead_new");
        check("dead_last_busy", busy, 1'b1);
        tick();
        check("rev_active", active, 3'd4);
        check("rev_busy", busy, 1'b0);
        count_en(256, cl, cr);
        check("rev_pwm_l", cl, 128);

        // req0 turns forward (another reversal), then req1 cannot take over.
        cmd[2:0] = 3'd1;
        ticks(6);
        check("own0_active", active, 3'd1);
        req = 3'b011;
        tick();
        check("nopreempt_grant", grant, 3'b001);
        req = 3'b010;
        tick();
        check("handover_grant", grant, 3'b010);
        check("handover_active", active, 3'd1);
        req = 3'b000;
        tick();
        check("idle_grant", grant, 3'b000);
        check("idle_active", active, 3'd0);
        check_off("idle");

        // Same owner: forward -> right reverses only the right side.
        req = 3'b010; cmd[5:3] = 3'd1;
        tick();
        check("f2r_fwd", active, 3'd1);
        cmd[5:3] = 3'd2;
        tick();
        check("f2r_busy", busy, 1'b1);
        ticks(4);
        check("f2r_dir", {dir_l, dir_r}, 2'b01);
        tick();
        check("f2r_active", active, 3'd2);
        cmd[5:3] = 3'd0;
        tick();
        check("stop_active", active, 3'd0);
        check("stop_busy", busy, 1'b0);
        cmd[5:3] = 3'd6;
        tick();
        check("code6_active", active, 3'd0);
        check("code6_busy", busy, 1'b0);
        check_off("code6");

        // Target changes to left during dead-time; counter is not restarted.
        cmd[5:3] = 3'd4;
        tick();
        check("chg_busy", busy, 1'b1);
        tick();
        cmd[5:3] = 3'd3;
        ticks(2);
        check("chg_old_dir", {dir_l, dir_r}, 2'b01);
        tick();
        check("chg_new_dir", {dir_l, dir_r}, 2'b10);
        tick();
        check("chg_active", active, 3'd3);
        check("chg_busy_end", busy, 1'b0);

        // Reset in the middle of dead-time.
        cmd[5:3] = 3'd1;
        ticks(2);
        check("rstdead_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("rstdead_grant", grant, 3'b000);
        check("rstdead_active", active, 3'd0);
        check("rstdead_busy0", busy, 1'b0);
        check("rstdead_dir", {dir_l, dir_r}, 2'b00);
        check_off("rstdead");

        // Duty boundaries: 0 keeps motors off, 255 gives 255 of 256.
        rst = 1'b0; duty = 8'd0;
        tick();
        check("d0_active", active, 3'd1);
        count_en(256, cl, cr);
        check("d0_pwm", cl + cr, 0);
        duty = 8'd255;
        tick();
        count_en(256, cl, cr);
        check("dmax_pwm_l", cl, 255);
        check("dmax_pwm_r", cr, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
